// File: rtl/packer_bs_writer_ctrl_if.sv
// packer_bs_writer_ctrl_if: groups the packer-stage handshake, the packer
// output FIFO read port and the bitstream buffer write port.
// master = the writer controller, slave = packer stage / FIFO / buffer side.
interface packer_bs_writer_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              packer_stage_start;
    logic              packer_stage_finish;
    logic [31:0]       fifo_data;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_pop;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              wr_ack;

    modport master (
        output packer_stage_start,
        input  packer_stage_finish,
        input  fifo_data,
        input  fifo_empty,
        input  fifo_full,
        output fifo_pop,
        output wr_req,
        output wr_addr,
        output wr_data,
        input  wr_ack
    );

    modport slave (
        input  packer_stage_start,
        output packer_stage_finish,
        output fifo_data,
        output fifo_empty,
        output fifo_full,
        input  fifo_pop,
        input  wr_req,
        input  wr_addr,
        input  wr_data,
        output wr_ack
    );
endinterface

// File: rtl/packer_bs_writer_ctrl.sv
// packer_bs_writer_ctrl: frame scheduler for the packer stage. Issues one
// packer_stage_start per macroblock and waits for packer_stage_finish, while a
// drain engine moves packer FIFO words into the bitstream buffer over req/ack.
// Enforces FIFO backpressure, a buffer-size limit (excess words are discarded
// and err_overflow is set), a final flush, and reports the written word count.
// Optional macro BS_BYTESWAP_EN: each captured word is byte-reversed before it
// is written (big-endian byte stream); undefined, words pass unchanged.
module packer_bs_writer_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int MB_CNT_W = 16,
    parameter int WCNT_W   = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       cfg_base_addr,
    input  logic [MB_CNT_W-1:0]     cfg_mb_total,
    input  logic [WCNT_W-1:0]       cfg_buf_words,
    packer_bs_writer_ctrl_if.master bus,
    output logic                    busy,
    output logic                    done,
    output logic [WCNT_W-1:0]       word_cnt,
    output logic                    err_overflow
);

    typedef enum logic [2:0] {IDLE, MB_START, MB_WAIT, FLUSH, DONE} state_t;
    typedef enum logic {D_IDLE, D_REQ} dstate_t;

    state_t                state_q, state_d;
    dstate_t               dstate_q, dstate_d;
    logic                  busy_q, busy_d;
    logic                  pss_q, pss_d;
    logic [MB_CNT_W-1:0]   mb_total_q, mb_total_d;
    logic [MB_CNT_W-1:0]   mb_idx_q, mb_idx_d;
    logic [WCNT_W-1:0]     buf_words_q, buf_words_d;
    logic [WCNT_W-1:0]     word_cnt_q, word_cnt_d;
    logic                  err_q, err_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;

    logic                  start_accept;
    logic                  drain_take;
    logic [MB_CNT_W-1:0]   mb_idx_inc;

    // Byte order of the word as it goes out to the buffer.
    function automatic logic [31:0] order_word(input logic [31:0] w);
`ifdef BS_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    assign mb_idx_inc = mb_idx_q + MB_CNT_W'(1);
    // Drain pops whenever the frame is live, the engine is free and a word waits.
    assign drain_take = busy_q && (dstate_q == D_IDLE) && !bus.fifo_empty;

    // State register: every flop cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dstate_q    <= D_IDLE;
            busy_q      <= 1'b0;
            pss_q       <= 1'b0;
            mb_total_q  <= '0;
            mb_idx_q    <= '0;
            buf_words_q <= '0;
            word_cnt_q  <= '0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            dstate_q    <= dstate_d;
            busy_q      <= busy_d;
            pss_q       <= pss_d;
            mb_total_q  <= mb_total_d;
            mb_idx_q    <= mb_idx_d;
            buf_words_q <= buf_words_d;
            word_cnt_q  <= word_cnt_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    // Main scheduler next state: frame start, per-MB start/finish, flush, done.
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        pss_d        = 1'b0;
        mb_total_d   = mb_total_q;
        mb_idx_d     = mb_idx_q;
        buf_words_d  = buf_words_q;
        start_accept = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_accept = 1'b1;
                    busy_d       = 1'b1;
                    mb_total_d   = cfg_mb_total;
                    buf_words_d  = cfg_buf_words;
                    mb_idx_d     = '0;
                    state_d      = (cfg_mb_total == '0) ? FLUSH : MB_START;
                end
            end
            MB_START: begin
                // Hold off the next macroblock while the FIFO is full.
                if (!bus.fifo_full) begin
                    pss_d   = 1'b1;
                    state_d = MB_WAIT;
                end
            end
            MB_WAIT: begin
                if (bus.packer_stage_finish) begin
                    mb_idx_d = mb_idx_inc;
                    state_d  = (mb_idx_inc == mb_total_q) ? FLUSH : MB_START;
                end
            end
            FLUSH: begin
                if (bus.fifo_empty && (dstate_q == D_IDLE)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Drain engine next state: pop/capture, buffer-limit check, write handshake.
    always_comb begin
        dstate_d   = dstate_q;
        word_cnt_d = word_cnt_q;
        err_d      = err_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if (start_accept) begin
            word_cnt_d = '0;
            err_d      = 1'b0;
            addr_d     = cfg_base_addr;
        end else begin
            case (dstate_q)
                D_IDLE: begin
                    if (drain_take) begin
                        wdata_d = order_word(bus.fifo_data);
                        // Past the buffer limit the word is dropped but the FIFO
                        // keeps draining so the packer never stalls forever.
                        if (word_cnt_q < buf_words_q) begin
                            dstate_d = D_REQ;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                D_REQ: begin
                    if (bus.wr_ack) begin
                        addr_d     = addr_q + ADDR_W'(4);
                        word_cnt_d = word_cnt_q + WCNT_W'(1);
                        dstate_d   = D_IDLE;
                    end
                end
                default: dstate_d = D_IDLE;
            endcase
        end
    end

    // Outputs decoded from registered state.
    always_comb begin
        bus.packer_stage_start = pss_q;
        bus.fifo_pop           = drain_take;
        bus.wr_req             = (dstate_q == D_REQ);
        bus.wr_addr            = addr_q;
        bus.wr_data            = wdata_q;
        busy                   = busy_q;
        done                   = (state_q == DONE);
        word_cnt               = word_cnt_q;
        err_overflow           = err_q;
    end

endmodule

// File: tb/tb_packer_bs_writer_ctrl.sv
// tb_packer_bs_writer_ctrl: scoreboard bench. A packer/FIFO/buffer model
// produces random words; each word's expected write (address, data) is queued
// when the word is generated, and per-frame totals are queued at frame start.
// A monitor compares the DUT's writes and done reports against those queues.
`timescale 1ns/1ps
module tb_packer_bs_writer_ctrl;

    localparam int ADDR_W   = 32;
    localparam int MB_CNT_W = 16;
    localparam int WCNT_W   = 20;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [ADDR_W-1:0]   cfg_base_addr;
    logic [MB_CNT_W-1:0] cfg_mb_total;
    logic [WCNT_W-1:0]   cfg_buf_words;
    logic                busy, done, err_overflow;
    logic [WCNT_W-1:0]   word_cnt;

    always #5 clk = ~clk;

    packer_bs_writer_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    packer_bs_writer_ctrl #(.ADDR_W(ADDR_W), .MB_CNT_W(MB_CNT_W), .WCNT_W(WCNT_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_base_addr(cfg_base_addr), .cfg_mb_total(cfg_mb_total), .cfg_buf_words(cfg_buf_words),
        .bus(bus),
        .busy(busy), .done(done), .word_cnt(word_cnt), .err_overflow(err_overflow)
    );

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { int wc; int err; int starts; int pops; } done_t;

    wr_t         exp_wr[$];
    done_t       exp_done[$];
    logic [31:0] fifo_q[$];

    int n_cmp = 0, n_fail = 0;

    // frame parameters shared with the environment model
    logic [31:0] f_base;
    int f_buf, f_wpm, pushed_cnt, first_word_en, ack_mode, last_wc;
    bit force_full;

    // environment state
    logic pop_s, pss_s, rst_s;
    int pk_busy, pk_timer, pk_left, req_age;

    // monitor state
    logic busy_prev;
    int f_pops, f_starts;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef BS_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic push_word();
        logic [31:0] w;
        wr_t e;
        w = (first_word_en != 0 && pushed_cnt == 0) ? 32'h1122_3344 : $urandom();
        fifo_q.push_back(w);
        if (pushed_cnt < f_buf) begin
            e.addr = f_base + 32'(4 * pushed_cnt);
            e.data = exp_word(w);
            exp_wr.push_back(e);
        end
        pushed_cnt++;
        pk_left--;
    endtask

    // Environment: packer stage, FIFO and buffer models, updated 1ns after posedge.
    initial begin
        bus.fifo_data = '0; bus.fifo_empty = 1'b1; bus.fifo_full = 1'b0;
        bus.packer_stage_finish = 1'b0; bus.wr_ack = 1'b0;
        pk_busy = 0; pk_timer = 0; pk_left = 0; req_age = 0;
        forever begin
            @(negedge clk);
            pop_s = bus.fifo_pop; pss_s = bus.packer_stage_start; rst_s = rst;
            @(posedge clk); #1;
            bus.packer_stage_finish = 1'b0;
            if (rst_s) begin
                fifo_q.delete(); pk_busy = 0; pk_left = 0;
            end else begin
                if (pop_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
                if (pss_s) begin
                    pk_busy = 1; pk_timer = $urandom_range(0, 3); pk_left = f_wpm;
                end else if (pk_busy != 0) begin
                    if (pk_timer > 0) pk_timer--;
                    else if (pk_left > 0) begin
                        if (fifo_q.size() < 64) push_word();
                    end else begin
                        bus.packer_stage_finish = 1'b1; pk_busy = 0;
                    end
                end
            end
            if (ack_mode == 0) bus.wr_ack = 1'b1;
            else if (bus.wr_req) begin
                if (ack_mode == 1) bus.wr_ack = ($urandom_range(0, 2) == 0);
                else bus.wr_ack = (req_age >= 5);
                req_age++;
            end else begin
                bus.wr_ack = 1'b0; req_age = 0;
            end
            bus.fifo_empty = (fifo_q.size() == 0);
            bus.fifo_data  = (fifo_q.size() == 0) ? 32'h0 : fifo_q[0];
            bus.fifo_full  = force_full || (fifo_q.size() >= 64);
        end
    end

    // Monitor: compares writes and done reports against the scoreboard queues.
    initial begin
        busy_prev = 1'b0; f_pops = 0; f_starts = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_prev = 1'b0;
            end else begin
                if (busy && !busy_prev) begin f_pops = 0; f_starts = 0; end
                busy_prev = busy;
                if (bus.fifo_pop) f_pops++;
                if (bus.packer_stage_start) f_starts++;
                if (bus.wr_req) begin
                    check("wr_expected", exp_wr.size() != 0, 1);
                    if (exp_wr.size() != 0) begin
                        check("wr_addr", bus.wr_addr, exp_wr[0].addr);
                        check("wr_data", bus.wr_data, exp_wr[0].data);
                        if (bus.wr_ack) void'(exp_wr.pop_front());
                    end
                end
                if (done) begin
                    done_t e;
                    check("done_expected", exp_done.size() != 0, 1);
                    if (exp_done.size() != 0) begin
                        e = exp_done.pop_front();
                        check("word_cnt", word_cnt, e.wc);
                        check("err_overflow", err_overflow, e.err);
                        check("stage_starts", f_starts, e.starts);
                        check("fifo_pops", f_pops, e.pops);
                        check("writes_left", exp_wr.size(), 0);
                    end
                end
            end
        end
    end

    task automatic start_frame(input logic [31:0] base, input int mbt, input int wpm,
                               input int bufw, input int mode, input int fw);
        done_t e;
        int tot;
        f_base = base; f_buf = bufw; f_wpm = wpm; pushed_cnt = 0;
        first_word_en = fw; ack_mode = mode;
        tot = mbt * wpm;
        e.wc = (tot < bufw) ? tot : bufw;
        e.err = (tot > bufw) ? 1 : 0;
        e.starts = mbt; e.pops = tot;
        last_wc = e.wc;
        exp_done.push_back(e);
        cfg_base_addr = base; cfg_mb_total = MB_CNT_W'(mbt); cfg_buf_words = WCNT_W'(bufw);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        bit seen;
        seen = 0; lat = 0;
        for (int k = 1; k <= 4000; k++) begin
            @(negedge clk);
            if (done) begin seen = 1; lat = k; break; end
        end
        if (!seen) begin
            n_cmp++; n_fail++;
            $display("FAIL done_timeout: no done within 4000 cycles, required one done pulse");
        end else begin
            // start during the DONE cycle must be ignored
            cfg_mb_total = 16'd5; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            check("busy_after_done", busy, 0);
            check("done_one_cycle", done, 0);
            check("word_cnt_hold", word_cnt, last_wc);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pss"}, bus.packer_stage_start, 0);
        check({tag, "_pop"}, bus.fifo_pop, 0);
        check({tag, "_wr_req"}, bus.wr_req, 0);
        check({tag, "_wr_addr"}, bus.wr_addr, 0);
        check({tag, "_wr_data"}, bus.wr_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_word_cnt"}, word_cnt, 0);
        check({tag, "_err"}, err_overflow, 0);
    endtask

    initial begin
        int lat;
        bit got;
        logic [31:0] r;
        rst = 1'b1; start = 1'b0; force_full = 0;
        cfg_base_addr = '0; cfg_mb_total = '0; cfg_buf_words = '0;
        f_base = '0; f_buf = 0; f_wpm = 0; pushed_cnt = 0; first_word_en = 0; ack_mode = 0; last_wc = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;

        // three MBs, two words each, ack tied high
        start_frame(32'h0000_1000, 3, 2, 100, 0, 0);
        wait_done(lat);

        // empty frame: done two cycles after start
        start_frame(32'h0000_3000, 0, 0, 10, 0, 0);
        wait_done(lat);
        check("mb0_done_latency", lat, 2);

        // FIFO full holds MB_START; a start while busy is ignored
        @(negedge clk); force_full = 1;
        @(posedge clk); #1;
        start_frame(32'h0000_2000, 2, 1, 10, 1, 0);
        cfg_mb_total = 16'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("full_no_start", bus.packer_stage_start, 0);
            if (i == 9) force_full = 0;
            else begin @(posedge clk); #1; end
        end
        @(negedge clk);
        check("full_drop_cycle", bus.packer_stage_start, 0);
        @(negedge clk);
        check("full_released_start", bus.packer_stage_start, 1);
        @(posedge clk); #1;
        wait_done(lat);

        // ack delayed 5 cycles
        start_frame(32'h0000_4000, 2, 2, 20, 2, 0);
        wait_done(lat);

        // buffer limit: 6 words into a 4-word buffer
        start_frame(32'h0000_6000, 3, 2, 4, 0, 0);
        wait_done(lat);

        // reset while waiting for a macroblock
        start_frame(32'h0000_5000, 4, 3, 50, 0, 0);
        got = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.packer_stage_start) begin got = 1; break; end
        end
        check("rst_reached_mb_wait", got, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_wr.delete(); exp_done.delete();
        @(negedge clk);
        check_all_zero("midrst");
        @(posedge clk); #1;

        // clean frame after reset; first word 0x11223344 exposes byte order
        start_frame(32'h0000_7000, 1, 1, 8, 0, 1);
        wait_done(lat);

        // address wrap past 2^32
        start_frame(32'hFFFF_FFF8, 2, 2, 10, 1, 0);
        wait_done(lat);

        // randomized frames
        for (int n = 0; n < 8; n++) begin
            r = $urandom();
            start_frame(r & 32'hFFFF_FFFC, $urandom_range(1, 6), $urandom_range(0, 5),
                        $urandom_range(1, 25), $urandom_range(0, 2), 0);
            wait_done(lat);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
